// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch responder between the PC and instruction memory.
// A fetch address that misses the one-entry buffer starts a read handshake
// (IDLE -> REQ -> WAIT). The returned word is captured into the buffer, and a
// later IDLE cycle presenting the same address reports iready.
//
// Ports
//   clk        in   system clock, all state on rising edge
//   RST        in   synchronous active-high reset
//   PCaddr     in   [31:0] fetch address from the PC
//   fetch_en   in   core requests an instruction at PCaddr
//   flush      in   invalidate the buffer (imem store / fence.i)
//   mem_busy   in   memory still servicing the read; low = mem_rdata valid
//   mem_rdata  in   [31:0] memory read data
//   mem_ren    out  memory read enable (REQ and WAIT)
//   mem_addr   out  [31:0] memory read address (registered request address)
//   instr      out  [31:0] buffered instruction word
//   iready     out  instr is valid for the current PCaddr
//   misaligned out  fetch_en with PCaddr[1:0] != 0
//   fetch_err  out  sticky memory timeout flag, cleared only by RST
module ifetch_unit #(
   parameter logic [31:0] RESET_INSTR = 32'h0000_0013,
   parameter int unsigned TIMEOUT     = 16
) (
   input  logic        clk,
   input  logic        RST,
   input  logic [31:0] PCaddr,
   input  logic        fetch_en,
   input  logic        flush,
   input  logic        mem_busy,
   input  logic [31:0] mem_rdata,
   output logic        mem_ren,
   output logic [31:0] mem_addr,
   output logic [31:0] instr,
   output logic        iready,
   output logic        misaligned,
   output logic        fetch_err
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT
   } state_t;

   state_t        state, state_n;
   logic          buf_valid;
   logic [31:0]   buf_addr;
   logic [31:0]   req_addr;
   logic [CW-1:0] wait_cnt;

   logic hit;
   logic load_req;
   logic capture;
   logic timeout;

   assign hit        = buf_valid && (buf_addr == PCaddr);
   assign misaligned = fetch_en && (PCaddr[1:0] != 2'b00);
   assign mem_addr   = req_addr;

   always_comb begin
      state_n  = state;
      load_req = 1'b0;
      capture  = 1'b0;
      timeout  = 1'b0;
      mem_ren  = 1'b0;
      iready   = 1'b0;
      case (state)
         S_IDLE: begin
            iready = fetch_en && hit && !flush;
            if (fetch_en && !misaligned && !hit) begin
               load_req = 1'b1;
               state_n  = S_REQ;
            end
         end
         S_REQ: begin
            mem_ren = 1'b1;
            state_n = S_WAIT;
         end
         S_WAIT: begin
            mem_ren = 1'b1;
            if (!mem_busy) begin
               capture = 1'b1;
               state_n = S_IDLE;
            end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
               timeout = 1'b1;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state     <= S_IDLE;
         buf_valid <= 1'b0;
         buf_addr  <= '0;
         req_addr  <= '0;
         instr     <= RESET_INSTR;
         wait_cnt  <= '0;
         fetch_err <= 1'b0;
      end else begin
         state <= state_n;
         if (load_req)
            req_addr <= PCaddr;
         if (state == S_REQ)
            wait_cnt <= '0;
         else if (state == S_WAIT && mem_busy && !timeout)
            wait_cnt <= wait_cnt + CW'(1);
         if (capture) begin
            instr     <= mem_rdata;
            buf_addr  <= req_addr;
            buf_valid <= 1'b1;
         end
         if (timeout) begin
            fetch_err <= 1'b1;
            buf_valid <= 1'b0;
         end
         // flush is applied last so it overrides a coincident capture
         if (flush) begin
            buf_valid <= 1'b0;
            instr     <= RESET_INSTR;
         end
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit against a transaction-level reference model.
module tb_ifetch_unit;

   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam int          TIMEOUT = 16;

   logic        tb_clk = 1'b0;
   logic        RST;
   logic [31:0] PCaddr;
   logic        fetch_en;
   logic        flush;
   logic        mem_busy;
   logic [31:0] mem_rdata;
   logic        mem_ren;
   logic [31:0] mem_addr;
   logic [31:0] instr;
   logic        iready;
   logic        misaligned;
   logic        fetch_err;

   always #5 tb_clk = ~tb_clk;

   ifetch_unit #(.RESET_INSTR(NOP), .TIMEOUT(TIMEOUT)) dut (
      .clk        (tb_clk),
      .RST        (RST),
      .PCaddr     (PCaddr),
      .fetch_en   (fetch_en),
      .flush      (flush),
      .mem_busy   (mem_busy),
      .mem_rdata  (mem_rdata),
      .mem_ren    (mem_ren),
      .mem_addr   (mem_addr),
      .instr      (instr),
      .iready     (iready),
      .misaligned (misaligned),
      .fetch_err  (fetch_err)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   // Reference model: a fetch is either absent or in flight; an in-flight
   // fetch spends one request cycle then counts busy cycles until data or
   // until the TIMEOUT-th busy cycle.
   bit          m_inflight;
   bit          m_first;
   int          m_busy_seen;
   logic [31:0] m_req;
   bit          m_bv;
   logic [31:0] m_ba;
   logic [31:0] m_instr;
   bit          m_err;

   task automatic model_reset();
      m_inflight  = 0;
      m_first     = 0;
      m_busy_seen = 0;
      m_req       = '0;
      m_bv        = 0;
      m_ba        = '0;
      m_instr     = NOP;
      m_err       = 0;
   endtask

   task automatic model_step();
      bit hit;
      hit = m_bv && (m_ba == PCaddr);
      if (RST) begin
         model_reset();
         return;
      end
      if (!m_inflight) begin
         if (fetch_en && PCaddr[1:0] == 2'b00 && !hit) begin
            m_inflight = 1;
            m_first    = 1;
            m_req      = PCaddr;
         end
      end else if (m_first) begin
         m_first     = 0;
         m_busy_seen = 0;
      end else if (!mem_busy) begin
         m_instr    = mem_rdata;
         m_ba       = m_req;
         m_bv       = 1;
         m_inflight = 0;
      end else begin
         m_busy_seen++;
         if (m_busy_seen == TIMEOUT) begin
            m_err      = 1;
            m_bv       = 0;
            m_inflight = 0;
         end
      end
      if (flush) begin
         m_bv    = 0;
         m_instr = NOP;
      end
   endtask

   task automatic check_outputs();
      bit hit;
      hit = m_bv && (m_ba == PCaddr);
      check("iready", {31'b0, iready}, {31'b0, !m_inflight && fetch_en && hit && !flush});
      check("mem_ren", {31'b0, mem_ren}, {31'b0, m_inflight});
      if (m_inflight)
         check("mem_addr", mem_addr, m_req);
      check("instr", instr, m_instr);
      check("misaligned", {31'b0, misaligned}, {31'b0, fetch_en && PCaddr[1:0] != 2'b00});
      check("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
   endtask

   function automatic logic [31:0] pick_addr();
      logic [31:0] tbl [4];
      tbl[0] = 32'h100; tbl[1] = 32'h104; tbl[2] = 32'h108; tbl[3] = 32'h102;
      return tbl[$urandom_range(0, 3)];
   endfunction

   initial begin
      int busy_pct;
      RST = 1'b1; PCaddr = 32'h100; fetch_en = 1'b0; flush = 1'b0;
      mem_busy = 1'b0; mem_rdata = 32'hDEADBEEF;
      model_reset();
      repeat (2) @(posedge tb_clk);
      @(negedge tb_clk);
      RST = 1'b0;
      #1;
      check("rst_iready", {31'b0, iready}, 32'd0);
      check("rst_mem_ren", {31'b0, mem_ren}, 32'd0);
      check("rst_instr", instr, 32'h13);
      check("rst_fetch_err", {31'b0, fetch_err}, 32'd0);

      // busy probability per block: zero-wait, moderate, slow, stuck (timeouts)
      for (int blk = 0; blk < 8; blk++) begin
         case (blk % 4)
            0: busy_pct = 0;
            1: busy_pct = 50;
            2: busy_pct = 85;
            default: busy_pct = 100;
         endcase
         for (int cyc = 0; cyc < 120; cyc++) begin
            @(negedge tb_clk);
            RST       = ($urandom_range(0, 149) == 0);
            fetch_en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) < 3)
               PCaddr = pick_addr();
            flush     = ($urandom_range(0, 24) == 0);
            mem_busy  = ($urandom_range(0, 99) < busy_pct);
            mem_rdata = $urandom;
            #1;
            check_outputs();
            @(posedge tb_clk);
            model_step();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
